// File: rtl/md_unit_if.sv
//------------------------------------------------------------------------------
// md_unit_if : operand/result bundle between EX and the multiply/divide unit.
// Revision   : 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface md_unit_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [3:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (output start, op, a, b, input busy, done, hi, lo);
    modport slave  (input start, op, a, b, output busy, done, hi, lo);
endinterface

`default_nettype wire

// File: rtl/md_unit.sv
//------------------------------------------------------------------------------
// md_unit : multi-cycle multiply/divide unit owning the architectural HI/LO.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module md_unit #(
    parameter int WIDTH       = 32,
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  wire logic   clk,
    input  wire logic   reset,
    md_unit_if.slave    md
);
    localparam int c_MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int c_CW   = $clog2(c_MAXC + 1);

    typedef enum logic [0:0] {S_IDLE = 1'b0, S_BUSY = 1'b1} state_t;

    state_t             r_state, w_state_n;
    logic [c_CW-1:0]    r_cnt, w_cnt_n;
    logic [WIDTH-1:0]   r_a, r_b, r_hi, r_lo, w_hi_n, w_lo_n;
    logic [3:0]         r_op;
    logic [2*WIDTH-1:0] r_acc;
    logic               r_busy, r_done, w_busy_n, w_done_n, w_cap;

    // Product on 2*WIDTH-extended operands gives the exact signed/unsigned result mod 2^(2W)
    logic [2*WIDTH-1:0] w_pa, w_pb, w_prod, w_res;
    logic               w_sgn, w_aneg, w_bneg;
    logic [WIDTH-1:0]   w_ma, w_mb, w_mbs, w_q, w_r, w_quo, w_rem;

    assign w_sgn  = ~r_op[0];
    assign w_pa   = w_sgn ? {{WIDTH{r_a[WIDTH-1]}}, r_a} : {{WIDTH{1'b0}}, r_a};
    assign w_pb   = w_sgn ? {{WIDTH{r_b[WIDTH-1]}}, r_b} : {{WIDTH{1'b0}}, r_b};
    assign w_prod = w_pa * w_pb;

    // Magnitude divide; most-negative / -1 falls out as quotient=a, remainder=0
    assign w_aneg = w_sgn & r_a[WIDTH-1];
    assign w_bneg = w_sgn & r_b[WIDTH-1];
    assign w_ma   = w_aneg ? (~r_a + 1'b1) : r_a;
    assign w_mb   = w_bneg ? (~r_b + 1'b1) : r_b;
    assign w_mbs  = (w_mb == '0) ? {{(WIDTH-1){1'b0}}, 1'b1} : w_mb;
    assign w_q    = w_ma / w_mbs;
    assign w_r    = w_ma % w_mbs;
    assign w_quo  = (w_aneg ^ w_bneg) ? (~w_q + 1'b1) : w_q;
    assign w_rem  = w_aneg ? (~w_r + 1'b1) : w_r;

    always_comb begin
        w_res = w_prod;
        case (r_op[2:1])
            2'b00: w_res = w_prod;
            2'b01: w_res = (r_b == '0) ? {r_a, {WIDTH{1'b1}}} : {w_rem, w_quo};
            2'b10: w_res = r_acc + w_prod;
            2'b11: w_res = r_acc - w_prod;
            default: w_res = w_prod;
        endcase
    end

    always_comb begin
        w_state_n = r_state;
        w_cnt_n   = r_cnt;
        w_hi_n    = r_hi;
        w_lo_n    = r_lo;
        w_busy_n  = r_busy;
        w_done_n  = 1'b0;
        w_cap     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (md.start) begin
                    if (md.op < 4'd8) begin
                        w_cap     = 1'b1;
                        w_cnt_n   = (md.op == 4'd2 || md.op == 4'd3) ?
                                    c_CW'(DIV_CYCLES) : c_CW'(MULT_CYCLES);
                        w_state_n = S_BUSY;
                        w_busy_n  = 1'b1;
                    end else if (md.op == 4'd8) begin
                        w_hi_n = md.a;
                    end else if (md.op == 4'd9) begin
                        w_lo_n = md.a;
                    end
                end
            end
            S_BUSY: begin
                if (r_cnt == c_CW'(1)) begin
                    w_hi_n    = w_res[2*WIDTH-1:WIDTH];
                    w_lo_n    = w_res[WIDTH-1:0];
                    w_done_n  = 1'b1;
                    w_busy_n  = 1'b0;
                    w_cnt_n   = '0;
                    w_state_n = S_IDLE;
                end else begin
                    w_cnt_n = r_cnt - 1'b1;
                end
            end
            default: begin
                w_state_n = S_IDLE;
                w_busy_n  = 1'b0;
                w_cnt_n   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_hi    <= '0;
            r_lo    <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_a     <= '0;
            r_b     <= '0;
            r_op    <= '0;
            r_acc   <= '0;
        end else begin
            r_state <= w_state_n;
            r_cnt   <= w_cnt_n;
            r_hi    <= w_hi_n;
            r_lo    <= w_lo_n;
            r_busy  <= w_busy_n;
            r_done  <= w_done_n;
            if (w_cap) begin
                r_a   <= md.a;
                r_b   <= md.b;
                r_op  <= md.op;
                r_acc <= {r_hi, r_lo};
            end
        end
    end

    assign md.busy = r_busy;
    assign md.done = r_done;
    assign md.hi   = r_hi;
    assign md.lo   = r_lo;
endmodule

`default_nettype wire
